// File: rtl/mem_scan_interface_if.sv
// Groups the start/operand, memory-master and result signals of mem_scan_interface.
// The slave modport is the scanner's view; the master modport is the host/memory side.
// Widths follow the parameters of the instance, which must match the attached scanner.
interface mem_scan_interface_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 32,
  parameter int RESULT_W = 32,
  parameter int COUNT_W  = 16
);
  logic                algorithm_enable;
  logic [ADDR_W-1:0]   base_address;
  logic [COUNT_W-1:0]  word_count;
  logic                mode;
  logic                mem_read_enable;
  logic                mem_write_enable;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_read_data;
  logic [DATA_W-1:0]   mem_write_data;
  logic                mem_read_ready;
  logic                mem_write_ready;
  logic                wait_request;
  logic [RESULT_W-1:0] shortest_distance;
  logic                ready;
  logic                busy;

  modport slave (
    input  algorithm_enable, base_address, word_count, mode,
    input  mem_read_data, mem_read_ready, mem_write_ready, wait_request,
    output mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
    output shortest_distance, ready, busy
  );

  modport master (
    output algorithm_enable, base_address, word_count, mode,
    output mem_read_data, mem_read_ready, mem_write_ready, wait_request,
    input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
    input  shortest_distance, ready, busy
  );
endinterface

// File: rtl/mem_scan_interface.sv
// Scans WORD_COUNT words from memory, reduces them (saturating sum or unsigned min), optionally writes the result back.
// Latency: count+2 cycles start-to-ready (count+3 with write-back) on a zero-wait memory; all outputs registered.
// Backpressure: each read/write beat is held with a stable address until ready=1 and wait_request=0 coincide.
module mem_scan_interface #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int RESULT_W   = 32,
  parameter int COUNT_W    = 16,
  parameter bit WRITE_BACK = 1'b1
) (
  input  logic                algorithm_clock,
  input  logic                algorithm_reset,
  mem_scan_interface_if.slave bus
);

  localparam logic [ADDR_W-1:0]   STRIDE   = ADDR_W'(DATA_W / 8);
  localparam logic [RESULT_W-1:0] DATA_MAX = RESULT_W'({DATA_W{1'b1}});

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  index_q, index_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                mode_q, mode_d;
  logic [RESULT_W-1:0] acc_q, acc_d;

  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [RESULT_W-1:0] dist_q, dist_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic [RESULT_W-1:0] data_ext;
  logic [RESULT_W:0]   sum_ext;
  logic [RESULT_W-1:0] fold_val;
  logic                read_accept;
  logic                write_accept;

  // Reduction step: accumulator combined with the zero-extended incoming word.
  always_comb begin
    data_ext = RESULT_W'(bus.mem_read_data);
    sum_ext  = {1'b0, acc_q} + {1'b0, data_ext};
    if (mode_q) begin
      fold_val = (data_ext < acc_q) ? data_ext : acc_q;
    end else begin
      fold_val = sum_ext[RESULT_W] ? {RESULT_W{1'b1}} : sum_ext[RESULT_W-1:0];
    end
  end

  assign read_accept  = bus.mem_read_ready  && !bus.wait_request;
  assign write_accept = bus.mem_write_ready && !bus.wait_request;

  // Next-state logic: operand latching, word folding and phase sequencing.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    base_d  = base_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.algorithm_enable) begin
          base_d  = bus.base_address;
          count_d = bus.word_count;
          mode_d  = bus.mode;
          acc_d   = bus.mode ? {RESULT_W{1'b1}} : '0;
          index_d = '0;
          if (bus.word_count != '0) begin
            state_d = READ;
          end else begin
            state_d = WRITE_BACK ? WRITE : DONE;
          end
        end
      end
      READ: begin
        if (read_accept) begin
          acc_d   = fold_val;
          index_d = index_q + COUNT_W'(1);
          if (index_q == count_q - COUNT_W'(1)) begin
            state_d = WRITE_BACK ? WRITE : DONE;
          end
        end
      end
      WRITE: begin
        if (write_accept) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output pre-computation from the upcoming state so the registered outputs line up with it;
  // ready/shortest_distance are taken from the DONE cycle and so appear one cycle later.
  always_comb begin
    rd_en_d = (state_d == READ);
    wr_en_d = (state_d == WRITE);
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == READ) begin
      addr_d = base_d + ADDR_W'(index_d) * STRIDE;
    end else if (state_d == WRITE) begin
      addr_d  = base_d + ADDR_W'(count_d) * STRIDE;
      wdata_d = (acc_d > DATA_MAX) ? {DATA_W{1'b1}} : acc_d[DATA_W-1:0];
    end
    ready_d = (state_q == DONE);
    dist_d  = (state_q == DONE) ? acc_q : dist_q;
    busy_d  = (state_d != IDLE);
  end

  // State, operand and output registers; reset drops any in-flight beat at once.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset) begin
    if (!algorithm_reset) begin
      state_q <= IDLE;
      index_q <= '0;
      count_q <= '0;
      base_q  <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dist_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dist_q  <= dist_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_read_enable   = rd_en_q;
  assign bus.mem_write_enable  = wr_en_q;
  assign bus.mem_addr          = addr_q;
  assign bus.mem_write_data    = wdata_q;
  assign bus.shortest_distance = dist_q;
  assign bus.ready             = ready_q;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_mem_scan_interface.sv
// Self-checking bench: two scanners (32-bit result with write-back, 16-bit result without)
// share one memory image; monitors pop expected beats/results pushed when each start is issued.
module tb_mem_scan_interface;
  logic algorithm_clock = 1'b0;
  logic algorithm_reset = 1'b1;
  always #5 algorithm_clock = ~algorithm_clock;

  mem_scan_interface_if #(.DATA_W(16), .ADDR_W(32), .RESULT_W(32), .COUNT_W(16)) bus0 ();
  mem_scan_interface_if #(.DATA_W(16), .ADDR_W(32), .RESULT_W(16), .COUNT_W(16)) bus1 ();

  mem_scan_interface #(.DATA_W(16), .ADDR_W(32), .RESULT_W(32), .COUNT_W(16), .WRITE_BACK(1'b1)) dut0 (
    .algorithm_clock(algorithm_clock), .algorithm_reset(algorithm_reset), .bus(bus0));
  mem_scan_interface #(.DATA_W(16), .ADDR_W(32), .RESULT_W(16), .COUNT_W(16), .WRITE_BACK(1'b0)) dut1 (
    .algorithm_clock(algorithm_clock), .algorithm_reset(algorithm_reset), .bus(bus1));

  logic [15:0] mem [0:1023];
  int checks = 0;
  int errors = 0;
  bit stall_mode = 1'b0;

  logic [31:0] exp_rd0 [$];
  logic [31:0] exp_wa0 [$];
  logic [15:0] exp_wd0 [$];
  logic [31:0] exp_res0 [$];
  logic [31:0] exp_rd1 [$];
  logic [31:0] exp_res1 [$];

  function automatic int widx(input logic [31:0] a);
    return int'(a[10:1]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected by the scoreboard", name);
  endtask

  // Reference: reduce cnt words at base with rw-bit saturation/identity.
  function automatic logic [31:0] ref_reduce(input logic [31:0] base, input int cnt, input bit md, input int rw);
    longint unsigned lim;
    longint unsigned acc;
    longint unsigned w;
    lim = (64'd1 << rw) - 64'd1;
    acc = md ? lim : 64'd0;
    for (int i = 0; i < cnt; i++) begin
      w = 64'(mem[widx(base + 32'(i) * 32'd2)]);
      if (md) acc = (w < acc) ? w : acc;
      else    acc = (acc + w > lim) ? lim : acc + w;
    end
    return acc[31:0];
  endfunction

  // Memory responder and scoreboard monitor for the write-back scanner (optional stalls).
  int age0 = 0;
  bit acc_prev0 = 1'b0;
  bit pend0 = 1'b0;
  logic [31:0] addr_prev0 = '0;
  always @(negedge algorithm_clock) begin
    logic acc_now;
    logic [31:0] e;
    if (!algorithm_reset) begin
      age0 = 0; acc_prev0 = 1'b0; pend0 = 1'b0;
      bus0.mem_read_ready = 1'b0; bus0.mem_write_ready = 1'b0; bus0.wait_request = 1'b0;
    end else begin
      if (acc_prev0 || !(bus0.mem_read_enable || bus0.mem_write_enable)) age0 = 0;
      if (bus0.mem_read_enable && bus0.mem_write_enable) check("rd_wr_exclusive", 1, 0);
      if (pend0 && (bus0.mem_read_enable || bus0.mem_write_enable)) check("addr_stable", bus0.mem_addr, addr_prev0);
      bus0.wait_request    = stall_mode && (age0 < 3);
      bus0.mem_read_ready  = bus0.mem_read_enable  && (!stall_mode || age0 >= 2);
      bus0.mem_write_ready = bus0.mem_write_enable && (!stall_mode || age0 >= 2);
      bus0.mem_read_data   = bus0.mem_read_ready ? mem[widx(bus0.mem_addr)] : 16'($urandom);
      acc_now = ((bus0.mem_read_enable && bus0.mem_read_ready) ||
                 (bus0.mem_write_enable && bus0.mem_write_ready)) && !bus0.wait_request;
      if (acc_now && bus0.mem_read_enable) begin
        if (exp_rd0.size() == 0) fail_now("dut0_unexpected_read");
        else begin e = exp_rd0.pop_front(); check("dut0_read_addr", bus0.mem_addr, e); end
      end
      if (acc_now && bus0.mem_write_enable) begin
        if (exp_wa0.size() == 0) fail_now("dut0_unexpected_write");
        else begin
          e = exp_wa0.pop_front();
          check("dut0_write_addr", bus0.mem_addr, e);
          check("dut0_write_data", bus0.mem_write_data, exp_wd0.pop_front());
        end
      end
      pend0 = (bus0.mem_read_enable || bus0.mem_write_enable) && !acc_now;
      addr_prev0 = bus0.mem_addr;
      acc_prev0 = acc_now;
      age0++;
      if (bus0.ready) begin
        if (exp_res0.size() == 0) fail_now("dut0_unexpected_ready");
        else check("dut0_result", bus0.shortest_distance, exp_res0.pop_front());
      end
    end
  end

  // Zero-wait memory responder and scoreboard monitor for the no-write-back scanner.
  always @(negedge algorithm_clock) begin
    if (!algorithm_reset) begin
      bus1.mem_read_ready = 1'b0; bus1.mem_write_ready = 1'b0; bus1.wait_request = 1'b0;
    end else begin
      bus1.wait_request    = 1'b0;
      bus1.mem_write_ready = 1'b1;
      bus1.mem_read_ready  = bus1.mem_read_enable;
      bus1.mem_read_data   = bus1.mem_read_enable ? mem[widx(bus1.mem_addr)] : 16'($urandom);
      if (bus1.mem_write_enable) fail_now("dut1_write_without_write_back");
      if (bus1.mem_read_enable) begin
        if (exp_rd1.size() == 0) fail_now("dut1_unexpected_read");
        else check("dut1_read_addr", bus1.mem_addr, exp_rd1.pop_front());
      end
      if (bus1.ready) begin
        if (exp_res1.size() == 0) fail_now("dut1_unexpected_ready");
        else check("dut1_result", bus1.shortest_distance, exp_res1.pop_front());
      end
    end
  end

  // Issue a start at the current negedge, push expectations, drop enable one cycle later.
  task automatic start_op(input int w, input logic [31:0] base, input int cnt, input bit md);
    logic [31:0] res;
    if (w == 0) begin
      res = ref_reduce(base, cnt, md, 32);
      bus0.algorithm_enable = 1'b1; bus0.base_address = base; bus0.word_count = 16'(cnt); bus0.mode = md;
      for (int i = 0; i < cnt; i++) exp_rd0.push_back(base + 32'(i) * 32'd2);
      exp_res0.push_back(res);
      exp_wa0.push_back(base + 32'(cnt) * 32'd2);
      exp_wd0.push_back((res > 32'hFFFF) ? 16'hFFFF : res[15:0]);
    end else begin
      res = ref_reduce(base, cnt, md, 16);
      bus1.algorithm_enable = 1'b1; bus1.base_address = base; bus1.word_count = 16'(cnt); bus1.mode = md;
      for (int i = 0; i < cnt; i++) exp_rd1.push_back(base + 32'(i) * 32'd2);
      exp_res1.push_back(res);
    end
    @(negedge algorithm_clock);
    if (w == 0) begin
      bus0.algorithm_enable = 1'b0; bus0.base_address = $urandom; bus0.word_count = 16'($urandom); bus0.mode = 1'($urandom);
    end else begin
      bus1.algorithm_enable = 1'b0; bus1.base_address = $urandom; bus1.word_count = 16'($urandom); bus1.mode = 1'($urandom);
    end
  endtask

  // Wait (bounded) for ready; lat>0 checks the negedge index at which it appears.
  task automatic wait_done(input int w, input int lat, input string name);
    int cyc = 1;
    while (!(w == 0 ? bus0.ready : bus1.ready) && cyc < 3000) begin
      @(negedge algorithm_clock);
      cyc++;
    end
    if (!(w == 0 ? bus0.ready : bus1.ready)) begin
      checks++; errors++;
      $display("FAIL %s_timeout: ready not seen within %0d cycles", name, cyc);
    end else if (lat > 0) begin
      check({name, "_latency"}, 64'(cyc), 64'(lat));
    end
  endtask

  task automatic post_done(input int w, input string name);
    @(negedge algorithm_clock);
    check({name, "_busy_after_ready"}, (w == 0) ? bus0.busy : bus1.busy, 0);
    check({name, "_ready_one_cycle"}, (w == 0) ? bus0.ready : bus1.ready, 0);
    check({name, "_queues_drained"},
          (w == 0) ? 64'(exp_rd0.size() + exp_wa0.size() + exp_res0.size()) : 64'(exp_rd1.size() + exp_res1.size()), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    logic [31:0] rb;
    int rc;
    bit rm;
    bus0.algorithm_enable = 1'b0; bus0.base_address = '0; bus0.word_count = '0; bus0.mode = 1'b0;
    bus1.algorithm_enable = 1'b0; bus1.base_address = '0; bus1.word_count = '0; bus1.mode = 1'b0;
    bus0.mem_read_data = '0; bus0.mem_read_ready = 1'b0; bus0.mem_write_ready = 1'b0; bus0.wait_request = 1'b0;
    bus1.mem_read_data = '0; bus1.mem_read_ready = 1'b0; bus1.mem_write_ready = 1'b0; bus1.wait_request = 1'b0;
    fill_random();
    #2 algorithm_reset = 1'b0;
    #1;
    check("reset_addr", bus0.mem_addr, 0);
    check("reset_dist", bus0.shortest_distance, 0);
    check("reset_ctrl", {bus0.mem_read_enable, bus0.mem_write_enable, bus0.mem_write_data, bus0.ready, bus0.busy}, 0);
    check("reset_dut1", {bus1.mem_read_enable, bus1.busy, bus1.ready, bus1.shortest_distance}, 0);
    repeat (3) @(negedge algorithm_clock);
    algorithm_reset = 1'b1;
    @(negedge algorithm_clock);

    // Basic sum with write-back, zero-wait.
    mem[widx(32'h100)] = 16'd3; mem[widx(32'h102)] = 16'd5; mem[widx(32'h104)] = 16'd7; mem[widx(32'h106)] = 16'd9;
    start_op(0, 32'h100, 4, 1'b0);
    wait_done(0, 4 + 3, "sum4");
    check("sum4_value", bus0.shortest_distance, 24);
    post_done(0, "sum4");

    // Minimum, then empty minimum (identity, no reads).
    @(negedge algorithm_clock);
    mem[widx(32'h200)] = 16'd40; mem[widx(32'h202)] = 16'd12; mem[widx(32'h204)] = 16'd31;
    start_op(0, 32'h200, 3, 1'b1);
    wait_done(0, 3 + 3, "min3");
    check("min3_value", bus0.shortest_distance, 12);
    post_done(0, "min3");
    @(negedge algorithm_clock);
    start_op(0, 32'h040, 0, 1'b1);
    wait_done(0, 3, "min0");
    check("min0_value", bus0.shortest_distance, 32'hFFFF_FFFF);
    post_done(0, "min0");

    // Saturation: 32-bit result keeps the carry but the written word clips; 16-bit result clips.
    @(negedge algorithm_clock);
    mem[widx(32'h180)] = 16'hFFFF; mem[widx(32'h182)] = 16'h0002;
    start_op(0, 32'h180, 2, 1'b0);
    wait_done(0, 2 + 3, "sat32");
    check("sat32_value", bus0.shortest_distance, 32'h0001_0001);
    post_done(0, "sat32");
    @(negedge algorithm_clock);
    start_op(1, 32'h180, 2, 1'b0);
    wait_done(1, 2 + 2, "sat16");
    check("sat16_value", bus1.shortest_distance, 16'hFFFF);
    post_done(1, "sat16");

    // Stalled memory: wait_request 3 cycles, ready 2 cycles late on every beat.
    @(negedge algorithm_clock);
    stall_mode = 1'b1;
    start_op(0, 32'h100, 4, 1'b0);
    wait_done(0, 0, "stall");
    check("stall_value", bus0.shortest_distance, 24);
    post_done(0, "stall");
    stall_mode = 1'b0;

    // Start strobe during READ with other operands must be ignored.
    @(negedge algorithm_clock);
    start_op(0, 32'h300, 6, 1'b0);
    @(negedge algorithm_clock);
    bus0.algorithm_enable = 1'b1; bus0.base_address = 32'h500; bus0.word_count = 16'd2; bus0.mode = 1'b1;
    @(negedge algorithm_clock);
    bus0.algorithm_enable = 1'b0;
    wait_done(0, 0, "ignore_en");
    post_done(0, "ignore_en");

    // Reset after two of four words: outputs clear immediately, then a fresh run completes.
    @(negedge algorithm_clock);
    start_op(0, 32'h100, 4, 1'b0);
    @(negedge algorithm_clock);
    @(posedge algorithm_clock);
    #2;
    check("midreset_words_left", 64'(exp_rd0.size()), 2);
    algorithm_reset = 1'b0;
    #1;
    check("midreset_addr", bus0.mem_addr, 0);
    check("midreset_dist", bus0.shortest_distance, 0);
    check("midreset_ctrl", {bus0.mem_read_enable, bus0.mem_write_enable, bus0.mem_write_data, bus0.ready, bus0.busy}, 0);
    exp_rd0.delete(); exp_wa0.delete(); exp_wd0.delete(); exp_res0.delete();
    repeat (3) @(negedge algorithm_clock);
    algorithm_reset = 1'b1;
    @(negedge algorithm_clock);
    start_op(0, 32'h100, 4, 1'b0);
    wait_done(0, 4 + 3, "after_reset");
    check("after_reset_value", bus0.shortest_distance, 24);

    // Back-to-back: next start issued in the ready cycle is taken on the following edge.
    start_op(0, 32'h200, 3, 1'b1);
    wait_done(0, 3 + 3, "b2b");
    check("b2b_value", bus0.shortest_distance, 12);
    post_done(0, "b2b");

    // Randomised operations on both scanners.
    for (int it = 0; it < 30; it++) begin
      @(negedge algorithm_clock);
      fill_random();
      rb = 32'($urandom_range(0, 768)) * 32'd2;
      rc = int'($urandom_range(0, 12));
      rm = 1'($urandom);
      stall_mode = 1'($urandom);
      start_op(0, rb, rc, rm);
      wait_done(0, stall_mode ? 0 : rc + 3, "rand0");
      post_done(0, "rand0");
      stall_mode = 1'b0;
      @(negedge algorithm_clock);
      start_op(1, rb, rc, rm);
      wait_done(1, rc + 2, "rand1");
      post_done(1, "rand1");
    end

    repeat (4) @(negedge algorithm_clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
